melody_sequencer: RTL and testbench

- Controller that sequences the note-index datapath for the music player.
- Steps a note index 0..LAST_NOTE at a tempo derived from clk.
- Holds each note for a per-note duration in beats, read from the external duration ROM, then inserts a silent gap before the next note.
- Supports start, pause, stop and loop. Drives the note-ROM address and the tone-generator enable.

---
 rtl/melody_sequencer.sv | 148 ++++++++++++++
 tb/tb_melody_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Note-index sequencer for the music player: steps notes at a beat tempo, holds each
// for its ROM duration, inserts a silent gap, and supports start/stop/pause/loop.
//   state | meaning
//   IDLE  | waiting for start, note_idx parked at 0
//   LOAD  | one cycle: latch duration of note_idx from the duration ROM
//   PLAY  | tone enabled, counting beats
//   GAP   | tone disabled, counting silent ticks before the next note
//   DONE  | melody finished, note_idx holds LAST_NOTE
module melody_sequencer #(
    parameter int TICK_DIV  = 5000000,
    parameter int LAST_NOTE = 148,
    parameter int GAP_TICKS = 1,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop_en,
    input  logic [3:0]       dur_in,
    output logic [IDX_W-1:0] note_idx,
    output logic             sound_en,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         beat_q, beat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [IDX_W-1:0]   idx_d;
    logic               sound_d, busy_d, done_d;
    logic               running, tick, advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            note_idx <= '0;
            sound_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            note_idx <= idx_d;
            sound_en <= sound_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        idx_d   = note_idx;
        advance = 1'b0;

        // Pause freezes the divider, so no tick can reach the counters or the state.
        running = ((state_q == PLAY) || (state_q == GAP)) && !pause;
        tick    = running && (div_q == DIV_W'(TICK_DIV - 1));

        if (running) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                div_d = '0;
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                div_d   = '0;
                beat_d  = (dur_in == 4'd0) ? 4'd1 : dur_in;
                state_d = PLAY;
            end
            PLAY: begin
                if (tick) begin
                    if (beat_q > 4'd1) begin
                        beat_d = beat_q - 4'd1;
                    end else if (GAP_TICKS > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_TICKS);
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q > GAP_W'(1)) begin
                        gap_d = gap_q - 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (note_idx < IDX_W'(LAST_NOTE)) begin
                idx_d   = note_idx + 1'b1;
                state_d = LOAD;
            end else if (loop_en) begin
                idx_d   = '0;
                state_d = LOAD;
            end else begin
                state_d = DONE;
            end
        end

        if (stop) begin
            state_d = IDLE;
            idx_d   = '0;
            div_d   = '0;
            beat_d  = '0;
            gap_d   = '0;
        end

        // Outputs are registered from the next state, so they align with the state they describe.
        sound_d = (state_d == PLAY) && !pause && !stop;
        busy_d  = (state_d == LOAD) || (state_d == PLAY) || (state_d == GAP);
        done_d  = (state_d == DONE) && (state_q != DONE);
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: output trace is compressed into runs of {busy,sound_en,done,note_idx}
// and each run is compared against expected runs queued by the stimulus.
module tb_melody_sequencer;

    typedef struct {
        logic [10:0] tup;
        int          len;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, start_b = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [3:0] rom [4];
    logic [3:0] dur_a, dur_b;
    logic [7:0] idx_a, idx_b;
    logic       sound_a, busy_a, done_a;
    logic       sound_b, busy_b, done_b;

    int n_vec = 0;
    int n_fail = 0;
    int edur [4];

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [10:0] cur_tup [2];
    int          cur_len [2];
    bit          started [2];

    always #5 clk = ~clk;

    assign dur_a = rom[idx_a[1:0]];
    assign dur_b = rom[idx_b[1:0]];

    melody_sequencer #(.TICK_DIV(4), .LAST_NOTE(3), .GAP_TICKS(1), .IDX_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .dur_in(dur_a), .note_idx(idx_a), .sound_en(sound_a),
        .busy(busy_a), .done(done_a)
    );

    melody_sequencer #(.TICK_DIV(4), .LAST_NOTE(3), .GAP_TICKS(0), .IDX_W(8)) u_nogap (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop), .pause(pause),
        .loop_en(loop_en), .dur_in(dur_b), .note_idx(idx_b), .sound_en(sound_b),
        .busy(busy_b), .done(done_b)
    );

    // len == 0 means the run length is not checked
    task automatic expect_seg(input int ch, input bit b, input bit s, input bit d,
                              input int idx, input int len);
        exp_t e;
        e.tup = {b, s, d, 8'(idx)};
        e.len = len;
        if (ch == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic expect_note(input int ch, input int n, input int d, input bit gap);
        expect_seg(ch, 1, 0, 0, n, 1);
        expect_seg(ch, 1, 1, 0, n, 4 * d);
        if (gap) expect_seg(ch, 1, 0, 0, n, 4);
    endtask

    task automatic expect_melody(input int ch, input bit gap);
        for (int n = 0; n < 4; n++) expect_note(ch, n, edur[n], gap);
    endtask

    task automatic expect_finish(input int ch);
        expect_seg(ch, 0, 0, 1, 3, 1);
        expect_seg(ch, 0, 0, 0, 3, 0);
    endtask

    task automatic emit(input int ch);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (ch == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (ch == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        n_vec++;
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_run ch%0d: got busy/snd/done/idx=%b/%b/%b/%0d len=%0d, required nothing",
                     ch, cur_tup[ch][10], cur_tup[ch][9], cur_tup[ch][8], cur_tup[ch][7:0], cur_len[ch]);
        end else if (e.tup !== cur_tup[ch] || (e.len != 0 && e.len != cur_len[ch])) begin
            n_fail++;
            $display("FAIL run ch%0d: got busy/snd/done/idx=%b/%b/%b/%0d len=%0d, required %b/%b/%b/%0d len=%0d",
                     ch, cur_tup[ch][10], cur_tup[ch][9], cur_tup[ch][8], cur_tup[ch][7:0], cur_len[ch],
                     e.tup[10], e.tup[9], e.tup[8], e.tup[7:0], e.len);
        end
    endtask

    task automatic observe(input int ch, input logic [10:0] t);
        if (!started[ch]) begin
            started[ch] = 1'b1;
            cur_tup[ch] = t;
            cur_len[ch] = 1;
        end else if (t === cur_tup[ch]) begin
            cur_len[ch]++;
        end else begin
            emit(ch);
            cur_tup[ch] = t;
            cur_len[ch] = 1;
        end
    endtask

    always @(negedge clk) begin
        observe(0, {busy_a, sound_a, done_a, idx_a});
        observe(1, {busy_b, sound_b, done_b, idx_b});
    end

    task automatic wait_done(input int ch, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            seen = (ch == 0) ? done_a : done_b;
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout ch%0d: got no done pulse, required one within %0d cycles", ch, max_cycles);
        end
    endtask

    task automatic pulse_start(input bit a, input bit b);
        start   = a;
        start_b = b;
        @(negedge clk);
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        rom[0] = 4'd2; rom[1] = 4'd1; rom[2] = 4'd3; rom[3] = 4'd1;
        edur[0] = 2;   edur[1] = 1;   edur[2] = 3;   edur[3] = 1;
        started[0] = 1'b0;
        started[1] = 1'b0;

        // reset held with random inputs, then released with no start
        expect_seg(0, 0, 0, 0, 0, 0);
        expect_seg(1, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            start_b = 1'($urandom_range(0, 1));
            stop    = 1'($urandom_range(0, 1));
            pause   = 1'($urandom_range(0, 1));
            loop_en = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 0; start_b = 0; stop = 0; pause = 0; loop_en = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // full melody, no loop
        expect_melody(0, 1);
        expect_finish(0);
        pulse_start(1, 0);
        wait_done(0, 200);

        // loop: two passes back to back, loop dropped during the second
        expect_melody(0, 1);
        expect_melody(0, 1);
        expect_finish(0);
        repeat (3) @(negedge clk);
        loop_en = 1'b1;
        pulse_start(1, 0);
        repeat (60) @(negedge clk);
        loop_en = 1'b0;
        wait_done(0, 200);

        // pause 3 cycles into note 0 for 10 cycles
        expect_seg(0, 1, 0, 0, 0, 1);
        expect_seg(0, 1, 1, 0, 0, 3);
        expect_seg(0, 1, 0, 0, 0, 10);
        expect_seg(0, 1, 1, 0, 0, 5);
        expect_seg(0, 1, 0, 0, 0, 4);
        for (int n = 1; n < 4; n++) expect_note(0, n, edur[n], 1);
        expect_finish(0);
        repeat (3) @(negedge clk);
        pulse_start(1, 0);
        repeat (3) @(negedge clk);
        pause = 1'b1;
        repeat (10) @(negedge clk);
        pause = 1'b0;
        wait_done(0, 200);

        // stop during note 2, then stop+start collision stays idle
        expect_note(0, 0, 2, 1);
        expect_note(0, 1, 1, 1);
        expect_seg(0, 1, 0, 0, 2, 1);
        expect_seg(0, 1, 1, 0, 2, 4);
        expect_seg(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        pulse_start(1, 0);
        repeat (26) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        stop = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        // start during PLAY ignored; async reset lands one cycle into the gap
        expect_seg(0, 1, 0, 0, 0, 1);
        expect_seg(0, 1, 1, 0, 0, 8);
        expect_seg(0, 1, 0, 0, 0, 1);
        expect_seg(0, 0, 0, 0, 0, 0);
        pulse_start(1, 0);
        repeat (3) @(negedge clk);
        pulse_start(1, 0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // zero duration note on both; no-gap instance runs notes back to back
        rom[1] = 4'd0;
        expect_melody(0, 1);
        expect_finish(0);
        expect_melody(1, 0);
        expect_finish(1);
        pulse_start(1, 1);
        wait_done(1, 200);
        wait_done(0, 200);

        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        emit(0);
        emit(1);
        while (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            n_vec++;
            n_fail++;
            $display("FAIL missing_run ch0: got nothing, required busy/snd/done/idx=%b/%b/%b/%0d len=%0d",
                     e.tup[10], e.tup[9], e.tup[8], e.tup[7:0], e.len);
        end
        while (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            n_vec++;
            n_fail++;
            $display("FAIL missing_run ch1: got nothing, required busy/snd/done/idx=%b/%b/%b/%0d len=%0d",
                     e.tup[10], e.tup[9], e.tup[8], e.tup[7:0], e.len);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
